id_fwd_interlock: RTL
=====================

Name: id_fwd_interlock

Overview:
- Decode-stage operand bypass network, load-use interlock and ID/EX pipeline register in one block.
- Generalises the fixed two-source (EX, MEM) forwarding to NUM_FWD prioritised sources and a configurable data width.
- Adds a load-use interlock FSM with a stall watchdog and a registered ID/EX output with stall and flush.
- Sits between the instruction decoder/regfile and the EX stage; stallreq feeds the pipeline controller.

Parameters:
- DW, 32: data/operand width.
- AW, 5: register address width.
- OPW, 8: aluop width.
- SELW, 3: alusel width.
- NUM_FWD, 2: number of forwarding sources; index 0 is the youngest (EX), higher indices are older (MEM, WB, ...).
- LOAD_LAT, 1: number of youngest sources whose load data is not yet valid (indices 0..LOAD_LAT-1).
- MAX_STALL, 15: consecutive interlock cycles before interlock_err is raised.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- id_reg1_read  in  1  operand 1 is read from a register.
- id_reg1_addr  in  AW  operand 1 register address.
- id_reg1_data  in  DW  regfile read data for operand 1.
- id_reg2_read  in  1  operand 2 is read from a register.
- id_reg2_addr  in  AW  operand 2 register address.
- id_reg2_data  in  DW  regfile read data for operand 2.
- id_imm  in  DW  immediate; used when the operand's read flag is 0.
- id_aluop  in  OPW  decoded aluop.
- id_alusel  in  SELW  decoded alusel.
- id_wd  in  AW  decoded destination register.
- id_wreg  in  1  decoded write enable.
- id_valid  in  1  ID holds a real instruction.
- fwd_wreg  in  NUM_FWD  per-source write enable.
- fwd_wd  in  NUM_FWD*AW  per-source destination; source k occupies bits [k*AW +: AW].
- fwd_wdata  in  NUM_FWD*DW  per-source result data.
- fwd_load  in  NUM_FWD  source k is a load whose data is not final.
- stall_i  in  1  downstream stall from the controller.
- flush_i  in  1  flush from the controller.
- ex_aluop  out  OPW  registered aluop.
- ex_alusel  out  SELW  registered alusel.
- ex_reg1  out  DW  registered operand 1.
- ex_reg2  out  DW  registered operand 2.
- ex_wd  out  AW  registered destination.
- ex_wreg  out  1  registered write enable.
- ex_valid  out  1  registered valid.
- stallreq  out  1  combinational request to stall IF/ID.
- interlock_err  out  1  sticky watchdog error.

Behaviour:
- Operand select, combinational, evaluated independently per operand:
  - If read flag is 0, the operand is id_imm.
  - Otherwise, take the lowest-index source k with fwd_wreg[k]=1, matching destination, and destination != 0; its data is fwd_wdata[k].
  - If no source matches, take the regfile data.
  - Address 0 is never forwarded; it always yields regfile data.
- Hazard, combinational: the selected source has k < LOAD_LAT, fwd_load[k]=1, and id_valid=1.
- stallreq = hazard when state is RUN or INTERLOCK; 0 in ERR.
- FSM states: RUN, INTERLOCK, ERR. Reset state is RUN.
  - RUN -> INTERLOCK on hazard.
  - INTERLOCK -> RUN when hazard clears.
  - In INTERLOCK, a cycle counter (width clog2(MAX_STALL+1)) increments each cycle with hazard=1 and stall_i=0, and clears on leaving INTERLOCK.
  - When the counter reaches MAX_STALL -> ERR; interlock_err=1, sticky until reset.
  - ERR -> RUN on flush_i; interlock_err stays 1.
- ID/EX register, updated on rising clk, in priority order:
  1. flush_i: bubble.
  2. stall_i: hold all outputs.
  3. hazard: bubble.
  4. Otherwise: load the decoded fields and selected operands; ex_valid=id_valid.
- Bubble: aluop=0, alusel=0, reg1=0, reg2=0, wd=0, wreg=0, valid=0.
- flush_i also forces the FSM to RUN and clears the stall counter.
- Simultaneous flush_i and hazard: flush wins; stallreq still reflects the hazard combinationally.
- Reset (rst=0, asynchronous, any cycle including mid-interlock):
  - All ex_* outputs 0, FSM RUN, counter 0, interlock_err 0.
  - stallreq is forced to 0 while rst=0.
- Latency: one cycle from ID inputs to ex_* outputs.

Optional Feature:
- Macro ID_STALL_PERF_EN.
- When defined:
  - Adds output port stall_cycles, 32 bits: counts every cycle with stallreq=1.
  - Saturates at 32'hFFFFFFFF.
  - Cleared only by reset.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Bypass priority: NUM_FWD=3, regfile=0x11, source 0 wd=5 data 0xAA, source 2 wd=5 data 0xBB, id_reg1_addr=5 -> next cycle ex_reg1=0xAA.
- Register zero: all sources wd=0, wreg=1, data 0xFF, id_reg2_addr=0, regfile=0 -> ex_reg2=0, stallreq=0.
- Load-use: source 0 fwd_load=1, wd=7, id_reg1_addr=7 -> stallreq=1, next ex_valid=0, ex_wreg=0; load retires next cycle -> stallreq=0, operand taken from source 1.
- Watchdog: MAX_STALL=3, hazard held 3 cycles -> interlock_err=1 and stallreq=0; assert flush_i -> FSM RUN, interlock_err stays 1.
- Stall vs flush: stall_i=1 with ex_aluop=0x21 held -> remains 0x21; stall_i=1 and flush_i=1 together -> bubble (all zero).
- Async reset mid-interlock: drop rst between clock edges -> ex_* outputs, stallreq and interlock_err go to 0 immediately; with ID_STALL_PERF_EN, stall_cycles=0.

Source files
------------

// File: rtl/id_fwd_interlock.sv
// Decode operand bypass, load-use interlock with stall watchdog, ID/EX register.
// ID_STALL_PERF_EN adds the saturating stall_cycles counter output.
module id_fwd_interlock #(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int OPW       = 8,
  parameter int SELW      = 3,
  parameter int NUM_FWD   = 2,
  parameter int LOAD_LAT  = 1,
  parameter int MAX_STALL = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_reg1_read,
  input  logic [AW-1:0]         id_reg1_addr,
  input  logic [DW-1:0]         id_reg1_data,
  input  logic                  id_reg2_read,
  input  logic [AW-1:0]         id_reg2_addr,
  input  logic [DW-1:0]         id_reg2_data,
  input  logic [DW-1:0]         id_imm,
  input  logic [OPW-1:0]        id_aluop,
  input  logic [SELW-1:0]       id_alusel,
  input  logic [AW-1:0]         id_wd,
  input  logic                  id_wreg,
  input  logic                  id_valid,
  input  logic [NUM_FWD-1:0]    fwd_wreg,
  input  logic [NUM_FWD*AW-1:0] fwd_wd,
  input  logic [NUM_FWD*DW-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]    fwd_load,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic [OPW-1:0]        ex_aluop,
  output logic [SELW-1:0]       ex_alusel,
  output logic [DW-1:0]         ex_reg1,
  output logic [DW-1:0]         ex_reg2,
  output logic [AW-1:0]         ex_wd,
  output logic                  ex_wreg,
  output logic                  ex_valid,
  output logic                  stallreq,
  output logic                  interlock_err
`ifdef ID_STALL_PERF_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int CW = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_LOCK,
    S_ERR
  } state_t;

  typedef struct packed {
    logic [OPW-1:0]  aluop;
    logic [SELW-1:0] alusel;
    logic [DW-1:0]   reg1;
    logic [DW-1:0]   reg2;
    logic [AW-1:0]   wd;
    logic            wreg;
    logic            valid;
  } id_ex_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          r_err;
  logic          w_err_set;
  id_ex_t        r_idex;
  id_ex_t        w_idex_ld;
  logic [DW-1:0] w_op1;
  logic [DW-1:0] w_op2;
  logic          w_ld1;
  logic          w_ld2;
  logic          w_hazard;

  // Descending scan so the youngest (lowest index) match wins.
  always_comb begin
    w_op1 = id_reg1_read ? id_reg1_data : id_imm;
    w_op2 = id_reg2_read ? id_reg2_data : id_imm;
    w_ld1 = 1'b0;
    w_ld2 = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (id_reg1_read && fwd_wreg[k] && id_reg1_addr != '0 &&
          fwd_wd[k*AW +: AW] == id_reg1_addr) begin
        w_op1 = fwd_wdata[k*DW +: DW];
        w_ld1 = (k < LOAD_LAT) && fwd_load[k];
      end
      if (id_reg2_read && fwd_wreg[k] && id_reg2_addr != '0 &&
          fwd_wd[k*AW +: AW] == id_reg2_addr) begin
        w_op2 = fwd_wdata[k*DW +: DW];
        w_ld2 = (k < LOAD_LAT) && fwd_load[k];
      end
    end
  end

  assign w_hazard = id_valid && (w_ld1 || w_ld2);
  assign stallreq = rst && w_hazard && (r_state != S_ERR);
  assign w_cnt_inc = r_cnt + CW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_set   = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_hazard) w_state_nxt = S_LOCK;
      end
      S_LOCK: begin
        if (!w_hazard) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else if (!stall_i) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CW'(MAX_STALL)) begin
            w_state_nxt = S_ERR;
            w_cnt_nxt   = '0;
            w_err_set   = 1'b1;
          end
        end
      end
      S_ERR: ;
      default: w_state_nxt = S_RUN;
    endcase
    if (flush_i) begin
      w_state_nxt = S_RUN;
      w_cnt_nxt   = '0;
      w_err_set   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_idex_ld.aluop  = id_aluop;
    w_idex_ld.alusel = id_alusel;
    w_idex_ld.reg1   = w_op1;
    w_idex_ld.reg2   = w_op2;
    w_idex_ld.wd     = id_wd;
    w_idex_ld.wreg   = id_wreg;
    w_idex_ld.valid  = id_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idex <= '0;
    end else if (flush_i) begin
      r_idex <= '0;
    end else if (stall_i) begin
      r_idex <= r_idex;
    end else if (w_hazard) begin
      r_idex <= '0;
    end else begin
      r_idex <= w_idex_ld;
    end
  end

  assign ex_aluop      = r_idex.aluop;
  assign ex_alusel     = r_idex.alusel;
  assign ex_reg1       = r_idex.reg1;
  assign ex_reg2       = r_idex.reg2;
  assign ex_wd         = r_idex.wd;
  assign ex_wreg       = r_idex.wreg;
  assign ex_valid      = r_idex.valid;
  assign interlock_err = r_err;

`ifdef ID_STALL_PERF_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
    end else if (stallreq && !(&r_stall_cycles)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule
